// File: rtl/hgcal_input_packer_pkg.sv
// Shared definitions for the HGCAL layer-0 input path: frame geometry, quantizer setup, feature slicing.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package hgcal_pkg;

    localparam int N_IN  = 48;  // cells (features) per frame
    localparam int IN_W  = 10;  // raw sensor word width, unsigned
    localparam int Q_W   = 2;   // quantized code width per feature
    localparam int SHIFT = 6;   // quantization step = 2^SHIFT

    // FILL: collecting beats into the shadow buffer.
    // HOLD: shadow holds a complete frame that is waiting for the output register.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pk_state_t;

    // Bit offset of feature i inside a packed frame. Layer-0 LUT wiring uses
    // the same mapping, so both sides agree on where each feature lives.
    function automatic int feat_lsb(input int i, input int qw);
        return i * qw;
    endfunction

endpackage

// File: rtl/hgcal_input_quant.sv
// Shift-and-saturate quantizer: code = min(i_data >> SHIFT, 2^Q_W - 1).
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of i_data.
// Ports: i_data (IN_W raw cell value), o_code (Q_W quantized code).
module hgcal_input_quant #(
    parameter int IN_W  = 10,
    parameter int Q_W   = 2,
    parameter int SHIFT = 6
) (
    input  logic [IN_W-1:0] i_data,
    output logic [Q_W-1:0]  o_code
);

    localparam logic [IN_W-1:0] MAX_Q = IN_W'((1 << Q_W) - 1);

    logic [IN_W-1:0] w_q;

    assign w_q    = i_data >> SHIFT;
    assign o_code = (w_q > MAX_Q) ? MAX_Q[Q_W-1:0] : w_q[Q_W-1:0];

endmodule

// File: rtl/hgcal_input_packer.sv
// Packs N_IN quantized cell beats into one registered flat frame for the layer-0 neuron LUTs.
// Latency: m_valid rises the cycle after the last-beat handshake; one beat per cycle sustained.
// Backpressure: double-buffered; s_ready drops only while a complete shadow frame waits for the output slot.
// Ports: clk; rst (async, active-low); s_data/s_valid/s_last/s_ready input stream;
//        m_data/m_valid/m_ready packed frame output; frame_err one-cycle pulse on a dropped malformed frame.
module hgcal_input_packer
    import hgcal_pkg::*;
#(
    parameter int N_IN  = hgcal_pkg::N_IN,
    parameter int IN_W  = hgcal_pkg::IN_W,
    parameter int Q_W   = hgcal_pkg::Q_W,
    parameter int SHIFT = hgcal_pkg::SHIFT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_W-1:0]      s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [N_IN*Q_W-1:0]  m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int DW    = N_IN * Q_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    pk_state_t        r_state;
    logic [IDX_W-1:0] r_idx;
    logic [DW-1:0]    r_shadow;
    logic [DW-1:0]    r_m_data;
    logic             r_m_valid;
    logic             r_s_ready;
    logic             r_frame_err;

    logic [Q_W-1:0]   w_code;
    logic [DW-1:0]    w_frame;
    logic             w_acc;
    logic             w_out_free;
    logic             w_at_end;

    hgcal_input_quant #(
        .IN_W  (IN_W),
        .Q_W   (Q_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .i_data (s_data),
        .o_code (w_code)
    );

    assign w_acc      = s_valid && r_s_ready;
    // Output register can take a new frame if empty or being drained this edge.
    assign w_out_free = !r_m_valid || m_ready;
    assign w_at_end   = (r_idx == LAST_IDX);

    // Shadow contents with the current beat's code merged into its slot; this
    // lets the final beat go straight to m_data without a second cycle.
    always_comb begin
        w_frame = r_shadow;
        w_frame[feat_lsb(int'(r_idx), Q_W) +: Q_W] = w_code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_FILL;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_s_ready   <= 1'b1;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            // Drained frame clears valid unless a new one is loaded below.
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                ST_FILL: begin
                    if (w_acc) begin
                        r_shadow <= w_frame;
                        if (w_at_end && s_last) begin
                            r_idx <= '0;
                            if (w_out_free) begin
                                r_m_data  <= w_frame;
                                r_m_valid <= 1'b1;
                            end else begin
                                r_state   <= ST_HOLD;
                                r_s_ready <= 1'b0;
                            end
                        end else if (w_at_end || s_last) begin
                            // Long or short frame: drop it, restart at slot 0.
                            r_idx       <= '0;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_out_free) begin
                        r_m_data  <= r_shadow;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_FILL;
                        r_s_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    assign s_ready   = r_s_ready;
    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Scoreboard bench for hgcal_input_packer: directed frames, expected frames queued at issue time.
// Latency: checks m_valid one cycle after the last-beat handshake and 48-cycle frame spacing.
// Backpressure: exercises held output, shadow HOLD and s_ready drop/recovery.
module tb_hgcal_input_packer;

    localparam int NB = 48;
    localparam int DW = 96;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [9:0]     s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  m_data;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic           frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_seen = 0;

    logic [127:0] exp_q[$];
    int           hs_cyc[$];

    int ramp_dat[8]  = '{0, 63, 64, 127, 128, 191, 192, 1023};
    int ramp_code[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    hgcal_input_packer dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] gen(input int seed, input int b);
        return 10'((seed * 131 + b * 29 + b * b * 7) % 1024);
    endfunction

    function automatic logic [1:0] qmodel(input logic [9:0] d);
        int q;
        q = int'(d) / 64;
        return (q > 3) ? 2'd3 : 2'(q);
    endfunction

    // Monitor: one negedge with m_valid && m_ready == one handshake at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) err_seen++;
            if (m_valid && m_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got %h expected no frame", m_data);
                end else begin
                    check("out_frame", {32'd0, m_data}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_beat(input logic [9:0] d, input logic last);
        int n = 0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got s_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int seed, input int nbeats, input int last_at,
                              input bit push, output logic [127:0] e);
        e = '0;
        for (int b = 0; b < nbeats; b++)
            if (b < NB) e[b*2 +: 2] = qmodel(gen(seed, b));
        if (push) exp_q.push_back(e);
        for (int b = 0; b < nbeats; b++)
            send_beat(gen(seed, b), b == last_at);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] e, fa, fb;
        int c0, e0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", {32'd0, m_data}, 0);
        check("rst_ferr", frame_err, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sready", s_ready, 1);

        // Reset mid-stream with a frame held on the output
        send_frame(1, NB, NB - 1, 0, e);
        check("pre_rst_mvalid", m_valid, 1);
        send_frame(2, 10, -1, 0, e);
        rst = 1'b0;
        #1;
        check("async_rst_mvalid", m_valid, 0);
        check("async_rst_mdata", {32'd0, m_data}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("in_rst_mvalid", m_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_sready", s_ready, 1);
        m_ready = 1'b1;
        send_frame(3, NB, NB - 1, 1, e);
        drain();

        // Quantizer ramp, hand-computed codes
        e = '0;
        for (int b = 0; b < NB; b++) e[b*2 +: 2] = 2'(ramp_code[b % 8]);
        exp_q.push_back(e);
        for (int b = 0; b < NB - 1; b++) send_beat(10'(ramp_dat[b % 8]), 1'b0);
        check("ramp_mvalid_before", m_valid, 0);
        send_beat(10'(ramp_dat[7]), 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("ramp_mvalid_after", m_valid, 1);
        drain();

        // Backpressure: frame A held, frame B parked in shadow
        m_ready = 1'b0;
        send_frame(10, NB, NB - 1, 1, fa);
        check("bp_a_mvalid", m_valid, 1);
        check("bp_a_mdata", {32'd0, m_data}, fa);
        send_frame(11, NB, NB - 1, 1, fb);
        check("bp_sready_low", s_ready, 0);
        check("bp_a_stable", {32'd0, m_data}, fa);
        repeat (3) @(posedge clk);
        #1;
        check("bp_a_stable2", {32'd0, m_data}, fa);
        check("bp_sready_low2", s_ready, 0);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check("bp_b_mvalid", m_valid, 1);
        check("bp_b_mdata", {32'd0, m_data}, fb);
        check("bp_sready_back", s_ready, 1);
        m_ready = 1'b1;
        drain();

        // Back-to-back frames at full rate
        hs_cyc.delete();
        c0 = cyc;
        send_frame(20, NB, NB - 1, 1, e);
        send_frame(21, NB, NB - 1, 1, e);
        send_frame(22, NB, NB - 1, 1, e);
        check("b2b_cycles", cyc - c0, 144);
        drain();
        check("b2b_outputs", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check("b2b_gap1", hs_cyc[1] - hs_cyc[0], 48);
            check("b2b_gap2", hs_cyc[2] - hs_cyc[1], 48);
        end

        // Short frame
        e0 = err_seen;
        send_frame(30, 21, 20, 0, e);
        check("short_ferr_pulse", frame_err, 1);
        repeat (2) @(posedge clk);
        #1;
        check("short_ferr_count", err_seen, e0 + 1);
        check("short_mvalid", m_valid, 0);
        send_frame(31, NB, NB - 1, 1, e);
        drain();

        // Long frame
        e0 = err_seen;
        send_frame(40, NB, -1, 0, e);
        check("long_ferr_pulse", frame_err, 1);
        repeat (2) @(posedge clk);
        #1;
        check("long_ferr_count", err_seen, e0 + 1);
        check("long_mvalid", m_valid, 0);
        send_frame(41, NB, NB - 1, 1, e);
        drain();

        check("ferr_total", err_seen, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hgcal_input_packer.md
Name: hgcal_input_packer

Overview:
- Upstream feeder for layer 0 of the HGCAL autoencoder LogicNet.
- Accepts raw sensor-cell words one per beat over a valid/ready stream and quantizes each to a Q_W-bit code with saturation.
- Assembles one full frame of N_IN codes and presents it as a single registered flat vector with valid/ready to the layer-0 neuron LUTs.
- Double-buffered, so the next frame can be collected while the current one is held downstream.

Parameters:
- N_IN, 48: cells (features) per frame.
- IN_W, 10: raw sensor word width, unsigned.
- Q_W, 2: quantized code width per feature.
- SHIFT, 6: right shift applied before saturation (quantization step = 2^SHIFT).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low. Single clock domain.
- s_data  in  IN_W  raw cell value.
- s_valid  in  1  input beat valid.
- s_last  in  1  marks the final beat of a frame.
- s_ready  out  1  block can accept a beat.
- m_data  out  N_IN*Q_W  packed frame; feature i occupies bits [i*Q_W +: Q_W].
- m_valid  out  1  m_data holds a complete frame.
- m_ready  in  1  layer 0 consumes the frame.
- frame_err  out  1  one-cycle pulse when a malformed frame is dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - m_valid=0, m_data=0, frame_err=0.
  - idx=0, shadow buffer cleared, shadow_full=0, s_ready=1 after release.
- Quantizer (combinational on s_data): q = s_data>>SHIFT; code = (q > 2^Q_W-1) ? 2^Q_W-1 : q[Q_W-1:0].
- Accept: a beat is accepted on a rising edge where s_valid && s_ready.
  - The accepted code is written to shadow[idx] and idx increments.
  - s_ready = !shadow_full. It is a registered state, not combinationally dependent on m_ready.
- Frame completion: accepted beat with idx==N_IN-1 && s_last.
  - If the output stage is free (!m_valid, or m_valid && m_ready in the same cycle), the same edge loads m_data = shadow merged with the current code, and m_valid rises.
  - Latency: m_valid is high in the cycle after the last-beat handshake. idx returns to 0.
  - Otherwise shadow_full=1 (state HOLD) and s_ready drops. On the first edge with (!m_valid || m_ready), shadow moves to m_data, m_valid=1, shadow_full=0, s_ready=1.
- States: FILL (accepting, idx 0..N_IN-1) and HOLD (shadow complete, waiting for output slot). HOLD->FILL on transfer.
- Output handshake: m_data is stable while m_valid && !m_ready. m_valid clears on a handshake unless a new frame is loaded on the same edge (back-to-back allowed).
- Malformed frames:
  - s_last accepted with idx<N_IN-1 (short frame): frame dropped, idx=0, frame_err pulses the next cycle.
  - idx==N_IN-1 accepted without s_last (long frame): frame dropped, idx=0, frame_err pulse. The next beat starts a fresh frame.
  - Dropped frames never affect m_data or m_valid.
- Throughput: with m_ready held high, one beat per cycle sustained, no bubbles between frames.
- Reset mid-frame or mid-HOLD: all partial data is discarded and m_valid drops immediately (asynchronous).

Decomposition:
- Shared package hgcal_pkg holds:
  - N_IN, IN_W, Q_W, SHIFT defaults.
  - The feature-slice helper function (index i -> bit offset i*Q_W), which layer-0 wiring also uses.
- One natural sub-module: hgcal_input_quant, the combinational shift-and-saturate quantizer. It is instantiated once on s_data.

Test Plan:
- Reset mid-stream: hold rst low after 10 beats, release, then send a full frame -> m_valid=0 during reset; the frame after release is correct, with no remnant data.
- Quantizer ramp: 48 beats with s_data = 0, 63, 64, 127, 128, 191, 192, 1023 repeating, s_last on beat 47, m_ready=1 -> codes 0,0,1,1,2,2,3,3 repeating in m_data; m_valid exactly one cycle after the last handshake.
- Backpressure: m_ready=0 while two full frames are sent -> frame 1 held stable on m_data; frame 2 fills the shadow; s_ready=0 after frame 2's last beat. Raise m_ready for one cycle -> frame 2 appears next cycle and s_ready returns to 1.
- Back-to-back: 3 consecutive frames with s_valid=1 and m_ready=1 continuously -> 144 accepted beats in 144 cycles; m_valid pulses once per frame, 48 cycles apart.
- Short frame: s_last on beat 20 -> frame_err=1 for one cycle, m_valid stays 0; the following 48-beat frame is output correctly.
- Long frame: beat 47 without s_last -> frame_err pulse, no output; the next 48-beat frame with correct s_last is output correctly.
